// File: rtl/vlan_demux_pkg.sv
// Shared types and constants for the VLAN virtual-switch demultiplexer.
// Dot1Q field geometry, default TPID and the steering FSM states.
package vlan_demux_pkg;

    localparam int VLAN_FIELD_W = 32;
    localparam int VLAN_TPID_W  = 16;
    localparam int VLAN_VID_W   = 12;

    localparam logic [VLAN_TPID_W-1:0] DEFAULT_VLAN_TPID = 16'h0081;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        FWD,
        DROP
    } state_e;

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry AXI-Stream register with a channel tag carried beside the beat.
// Contents stay stable while the consumer withholds ready.
module axis_reg_slice #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128,
    parameter int SEL_W  = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DATA_W-1:0]   in_data_i,
    input  logic [DATA_W/8-1:0] in_keep_i,
    input  logic [USER_W-1:0]   in_user_i,
    input  logic                in_last_i,
    input  logic [SEL_W-1:0]    in_sel_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_W-1:0]   out_data_o,
    output logic [DATA_W/8-1:0] out_keep_o,
    output logic [USER_W-1:0]   out_user_o,
    output logic                out_last_o,
    output logic [SEL_W-1:0]    out_sel_o
);

    logic                valid_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W/8-1:0] keep_q;
    logic [USER_W-1:0]   user_q;
    logic                last_q;
    logic [SEL_W-1:0]    sel_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_keep_o  = keep_q;
    assign out_user_o  = user_q;
    assign out_last_o  = last_q;
    assign out_sel_o   = sel_q;

    // Load on an input handshake, empty when the held beat is taken.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            user_q  <= '0;
            last_q  <= 1'b0;
            sel_q   <= '0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
            keep_q  <= in_keep_i;
            user_q  <= in_user_i;
            last_q  <= in_last_i;
            sel_q   <= in_sel_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/vlan_vswitch_demux.sv
// Steers each AXI-Stream packet to one virtual-switch pipeline by VLAN ID.
// Untagged or out-of-range packets are swallowed and counted.
module vlan_vswitch_demux
    import vlan_demux_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_VSWITCHES      = 4,
    parameter int VLAN_ID_BASE       = 1,
    parameter int VLAN_LSB           = 96,
    parameter logic [15:0] VLAN_TPID = DEFAULT_VLAN_TPID
) (
    input  logic                                          axis_aclk,
    input  logic                                          axis_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]                  s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]                s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]                 s_axis_tuser,
    input  logic                                          s_axis_tvalid,
    input  logic                                          s_axis_tlast,
    output logic                                          s_axis_tready,
    output logic [NUM_VSWITCHES*C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [NUM_VSWITCHES*C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [NUM_VSWITCHES*C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic [NUM_VSWITCHES-1:0]                      m_axis_tvalid,
    output logic [NUM_VSWITCHES-1:0]                      m_axis_tlast,
    input  logic [NUM_VSWITCHES-1:0]                      m_axis_tready,
    output logic [31:0]                                   drop_count
);

    localparam int W     = C_AXIS_DATA_WIDTH;
    localparam int SEL_W = (NUM_VSWITCHES > 1) ? $clog2(NUM_VSWITCHES) : 1;

    state_e             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic [31:0]        drop_cnt_q;

    logic [VLAN_TPID_W-1:0] tpid;
    logic [VLAN_VID_W-1:0]  vid;
    logic [VLAN_VID_W-1:0]  ch;
    logic                   hit;
    logic                   acc;
    logic                   drop_ev;

    logic             sl_in_valid;
    logic             sl_in_ready;
    logic [SEL_W-1:0] sl_in_sel;
    logic             sl_out_valid;
    logic             sl_out_ready;
    logic [W-1:0]     sl_data;
    logic [W/8-1:0]   sl_keep;
    logic [C_AXIS_TUSER_WIDTH-1:0] sl_user;
    logic             sl_last;
    logic [SEL_W-1:0] sl_sel;

    assign tpid = s_axis_tdata[VLAN_LSB +: VLAN_TPID_W];
    assign vid  = {s_axis_tdata[VLAN_LSB+16 +: 4],
                   s_axis_tdata[VLAN_LSB+24 +: 8]};
    assign ch   = vid - VLAN_VID_W'(VLAN_ID_BASE);
    assign hit  = (tpid == VLAN_TPID) &&
                  (ch < VLAN_VID_W'(NUM_VSWITCHES));

    // Misses in IDLE obey the slice rule so they never pass a held beat.
    assign s_axis_tready = axis_resetn &&
                           ((state_q == SYNC) || (state_q == DROP) ||
                            sl_in_ready);
    assign acc = s_axis_tvalid && s_axis_tready;

    assign sl_in_valid = acc &&
                         (((state_q == IDLE) && hit) || (state_q == FWD));
    assign sl_in_sel   = (state_q == IDLE) ? ch[SEL_W-1:0] : sel_q;

    assign drop_ev = acc && s_axis_tlast &&
                     (((state_q == IDLE) && !hit) || (state_q == DROP));

    axis_reg_slice #(
        .DATA_W (W),
        .USER_W (C_AXIS_TUSER_WIDTH),
        .SEL_W  (SEL_W)
    ) u_slice (
        .clk_i       (axis_aclk),
        .rst_ni      (axis_resetn),
        .in_valid_i  (sl_in_valid),
        .in_ready_o  (sl_in_ready),
        .in_data_i   (s_axis_tdata),
        .in_keep_i   (s_axis_tkeep),
        .in_user_i   (s_axis_tuser),
        .in_last_i   (s_axis_tlast),
        .in_sel_i    (sl_in_sel),
        .out_valid_o (sl_out_valid),
        .out_ready_i (sl_out_ready),
        .out_data_o  (sl_data),
        .out_keep_o  (sl_keep),
        .out_user_o  (sl_user),
        .out_last_o  (sl_last),
        .out_sel_o   (sl_sel)
    );

    assign m_axis_tdata = {NUM_VSWITCHES{sl_data}};
    assign m_axis_tkeep = {NUM_VSWITCHES{sl_keep}};
    assign m_axis_tuser = {NUM_VSWITCHES{sl_user}};
    assign sl_out_ready = |(m_axis_tready & m_axis_tvalid);
    assign drop_count   = drop_cnt_q;

    // Fan the held beat's valid/last out to its own channel only.
    always_comb begin
        m_axis_tvalid = '0;
        m_axis_tlast  = '0;
        for (int i = 0; i < NUM_VSWITCHES; i++) begin
            m_axis_tvalid[i] = sl_out_valid && (sl_sel == SEL_W'(i));
            m_axis_tlast[i]  = m_axis_tvalid[i] && sl_last;
        end
    end

    // Packet-boundary tracking and channel latch on each accepted beat.
    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            state_q <= SYNC;
            sel_q   <= '0;
        end else if (acc) begin
            unique case (state_q)
                SYNC: if (s_axis_tlast) state_q <= IDLE;
                IDLE: begin
                    if (hit) begin
                        sel_q <= ch[SEL_W-1:0];
                        if (!s_axis_tlast) state_q <= FWD;
                    end else if (!s_axis_tlast) begin
                        state_q <= DROP;
                    end
                end
                FWD:  if (s_axis_tlast) state_q <= IDLE;
                DROP: if (s_axis_tlast) state_q <= IDLE;
            endcase
        end
    end

    // Saturating count of packets discarded at their last beat.
    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            drop_cnt_q <= '0;
        end else if (drop_ev && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_vlan_vswitch_demux.sv
// Scoreboard bench for vlan_vswitch_demux: packet-level routing model,
// per-channel expected queues and a decoupled output monitor.
module tb_vlan_vswitch_demux;

    localparam int W  = 256;
    localparam int KW = W / 8;
    localparam int TU = 128;
    localparam int N  = 4;

    typedef struct {
        logic [W-1:0]  d;
        logic [KW-1:0] k;
        logic [TU-1:0] u;
        logic          l;
    } beat_t;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [W-1:0]    s_tdata = '0;
    logic [KW-1:0]   s_tkeep = '0;
    logic [TU-1:0]   s_tuser = '0;
    logic            s_tvalid = 1'b0;
    logic            s_tlast = 1'b0;
    logic            s_tready;
    logic [N*W-1:0]  m_tdata;
    logic [N*KW-1:0] m_tkeep;
    logic [N*TU-1:0] m_tuser;
    logic [N-1:0]    m_tvalid;
    logic [N-1:0]    m_tlast;
    logic [N-1:0]    m_tready = '1;
    logic [31:0]     drop_count;

    vlan_vswitch_demux dut (
        .axis_aclk     (clk),
        .axis_resetn   (rstn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    beat_t       exp_q[N][$];
    beat_t       held[N];
    logic [N-1:0] held_v = '0;
    logic [31:0] exp_drop = 0;
    bit          in_sync = 1'b1;
    int          rdy_mode = 0;
    int          acc_cnt = 0;

    beat_t pkt[$];
    int    route;

    task automatic chk(input string nm, input logic [W-1:0] got,
                       input logic [W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Downstream ready generator
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) m_tready = '1;
        else if (rdy_mode == 1) m_tready = 4'($urandom);
    end

    // Output monitor: pops the expected queue of the channel that fires
    always @(negedge clk) begin
        if (!rstn) begin
            held_v = '0;
        end else begin
            chk("onehot", W'($countones(m_tvalid) <= 1), W'(1));
            chk("tlast_lane", W'(m_tlast & ~m_tvalid), '0);
            for (int c = 0; c < N; c++) begin
                beat_t cur;
                cur.d = m_tdata[c*W +: W];
                cur.k = m_tkeep[c*KW +: KW];
                cur.u = m_tuser[c*TU +: TU];
                cur.l = m_tlast[c];
                if (held_v[c] && !m_tvalid[c]) begin
                    chk("held_lost", W'(m_tvalid[c]), W'(1));
                    held_v[c] = 1'b0;
                end
                if (m_tvalid[c]) begin
                    if (held_v[c]) begin
                        chk("stable_d", cur.d, held[c].d);
                        chk("stable_l", W'(cur.l), W'(held[c].l));
                    end
                    if (m_tready[c]) begin
                        held_v[c] = 1'b0;
                        if (exp_q[c].size() == 0) begin
                            chk($sformatf("unexpected_ch%0d", c),
                                W'(1), W'(0));
                        end else begin
                            beat_t e;
                            e = exp_q[c].pop_front();
                            chk($sformatf("data_ch%0d", c), cur.d, e.d);
                            chk($sformatf("keep_ch%0d", c), W'(cur.k), W'(e.k));
                            chk($sformatf("user_ch%0d", c), W'(cur.u), W'(e.u));
                            chk($sformatf("last_ch%0d", c), W'(cur.l), W'(e.l));
                        end
                    end else begin
                        held_v[c] = 1'b1;
                        held[c]   = cur;
                    end
                end
            end
        end
    end

    // Build a packet and decide its fate from the VLAN rules
    task automatic make_pkt(input logic [15:0] tpid, input logic [11:0] vid,
                            input int len);
        pkt.delete();
        for (int i = 0; i < len; i++) begin
            beat_t b;
            for (int j = 0; j < W / 32; j++) b.d[j*32 +: 32] = $urandom;
            for (int j = 0; j < TU / 32; j++) b.u[j*32 +: 32] = $urandom;
            b.k = $urandom;
            b.l = (i == len - 1);
            if (i == 0) begin
                b.d[111:96]  = tpid;
                b.d[115:112] = vid[11:8];
                b.d[127:120] = vid[7:0];
            end
            pkt.push_back(b);
        end
        if (in_sync) route = -2;
        else if (tpid == 16'h0081 && vid >= 1 && vid <= N) route = vid - 1;
        else route = -1;
    endtask

    task automatic drive_beat(input beat_t b, input int gap, output int waits);
        if (gap > 0) begin
            s_tvalid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        s_tdata  = b.d;
        s_tkeep  = b.k;
        s_tuser  = b.u;
        s_tlast  = b.l;
        s_tvalid = 1'b1;
        waits = 0;
        forever begin
            bit rdy;
            @(negedge clk);
            rdy = s_tready;
            waits++;
            @(posedge clk);
            #1;
            if (rdy) break;
            if (waits > 2000) begin
                chk("accept_timeout", W'(0), W'(1));
                break;
            end
        end
        acc_cnt++;
        if (route >= 0) exp_q[route].push_back(b);
        if (b.l) begin
            if (route == -1 && exp_drop != 32'hFFFF_FFFF) exp_drop++;
            if (route == -2) in_sync = 1'b0;
        end
    endtask

    task automatic send_pkt(input logic [15:0] tpid, input logic [11:0] vid,
                            input int len, input int gap_max);
        int w;
        make_pkt(tpid, vid, len);
        for (int i = 0; i < len; i++)
            drive_beat(pkt[i], $urandom_range(0, gap_max), w);
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() +
                exp_q[3].size()) != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 2000) chk("drain_timeout", W'(0), W'(1));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        rstn = 1'b0;
        for (int c = 0; c < N; c++) exp_q[c].delete();
        exp_drop = 0;
        in_sync = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_tready", W'(s_tready), W'(0));
        chk("rst_tvalid", W'(m_tvalid), W'(0));
        chk("rst_tlast", W'(m_tlast), W'(0));
        chk("rst_tdata", W'(|m_tdata), W'(0));
        chk("rst_tkeep_tuser", W'(|m_tkeep | |m_tuser), W'(0));
        chk("rst_drop", W'(drop_count), W'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        // one single-beat packet to pass the post-reset SYNC state
        send_pkt(16'h0000, 12'd0, 1, 0);
    endtask

    initial begin
        int w;
        rdy_mode = 0;
        do_reset();

        // 4-beat VID 1 packet with one-cycle latency check
        make_pkt(16'h0081, 12'd1, 4);
        drive_beat(pkt[0], 0, w);
        chk("latency_tvalid", W'(m_tvalid), W'(4'b0001));
        for (int i = 1; i < 4; i++) drive_beat(pkt[i], 0, w);
        s_tvalid = 1'b0;
        drain();
        chk("drop_after_fwd", W'(drop_count), W'(exp_drop));

        // back-to-back single-beat packets, VIDs 2,3,4,2
        begin
            logic [11:0] vids [4] = '{12'd2, 12'd3, 12'd4, 12'd2};
            for (int i = 0; i < 4; i++) begin
                make_pkt(16'h0081, vids[i], 1);
                drive_beat(pkt[0], 0, w);
                chk("b2b_no_wait", W'(w), W'(1));
            end
            s_tvalid = 1'b0;
        end
        drain();

        // untagged and out-of-range packets, then a good one
        send_pkt(16'h0008, 12'd1, 3, 1);
        send_pkt(16'h0081, 12'd9, 2, 1);
        drain();
        chk("drop_two", W'(drop_count), W'(32'd2));
        chk("drop_model", W'(drop_count), W'(exp_drop));
        send_pkt(16'h0081, 12'd1, 3, 0);
        drain();

        // channel 2 stall mid-packet
        rdy_mode = 2;
        m_tready = '1;
        acc_cnt = 0;
        fork
            send_pkt(16'h0081, 12'd3, 6, 0);
            begin
                int t = 0;
                while (acc_cnt < 2 && t < 1000) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                m_tready[2] = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_tready", W'(s_tready), W'(0));
                    @(posedge clk);
                    #1;
                end
                m_tready[2] = 1'b1;
            end
        join
        drain();
        rdy_mode = 0;

        // reset during beat 2 of a 5-beat VID 1 packet
        make_pkt(16'h0081, 12'd1, 5);
        drive_beat(pkt[0], 0, w);
        drive_beat(pkt[1], 0, w);
        s_tvalid = 1'b0;
        rstn = 1'b0;
        for (int c = 0; c < N; c++) exp_q[c].delete();
        exp_drop = 0;
        in_sync = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_tvalid", W'(m_tvalid), W'(0));
        chk("mid_rst_tlast", W'(m_tlast), W'(0));
        chk("mid_rst_tdata", W'(|m_tdata), W'(0));
        chk("mid_rst_tready", W'(s_tready), W'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        route = -2;
        for (int i = 2; i < 5; i++) drive_beat(pkt[i], 0, w);
        s_tvalid = 1'b0;
        send_pkt(16'h0081, 12'd2, 3, 0);
        drain();
        chk("mid_rst_drop", W'(drop_count), W'(0));

        // randomized traffic with random backpressure
        rdy_mode = 1;
        for (int p = 0; p < 150; p++) begin
            logic [15:0] tp;
            tp = ($urandom_range(0, 5) == 0) ? 16'h0800 : 16'h0081;
            send_pkt(tp, 12'($urandom_range(0, 6)),
                     $urandom_range(1, 4), $urandom_range(0, 2));
        end
        drain();
        chk("rand_drop", W'(drop_count), W'(exp_drop));
        rdy_mode = 0;

        // saturation of the drop counter
        @(negedge clk);
        force dut.drop_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.drop_cnt_q;
        exp_drop = 32'hFFFF_FFFE;
        send_pkt(16'h1234, 12'd1, 1, 0);
        drain();
        chk("sat_reach", W'(drop_count), W'(exp_drop));
        send_pkt(16'h1234, 12'd1, 2, 0);
        send_pkt(16'h0081, 12'd15, 1, 0);
        drain();
        chk("sat_hold", W'(drop_count), W'(32'hFFFF_FFFF));
        chk("sat_model", W'(drop_count), W'(exp_drop));

        for (int c = 0; c < N; c++)
            chk($sformatf("leftover_ch%0d", c), W'(exp_q[c].size()), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
